// File: rtl/lpc_pkg.sv
// ----------------------------------------------------------------------------
// lpc_pkg
// Shared types and constants for the LPC register-bank write arbiter.
//   HOST_SRC      : RegSrc code reported for host-originated writes
//   LOCK_ADDR_DEF : default register address whose bit0 locks internal writes
//   IDX_W         : width of requester index / round-robin pointer (NUM_REQ <= 4)
//   lock_state_t  : host lock FSM states
//   reg_wr_t      : one register-bank write (address + data)
// ----------------------------------------------------------------------------
package lpc_pkg;

    localparam logic [2:0] HOST_SRC      = 3'd7;
    localparam logic [7:0] LOCK_ADDR_DEF = 8'h1F;
    localparam int         IDX_W         = 2;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } reg_wr_t;

endpackage

// File: rtl/lpc_rr_pick.sv
// ----------------------------------------------------------------------------
// lpc_rr_pick
// Combinational round-robin picker: returns the first set bit of i_mask at or
// after i_ptr, wrapping from NUM_REQ-1 back to 0.
//   i_mask  : eligible requesters
//   i_ptr   : round-robin start position (always < NUM_REQ)
//   o_valid : at least one eligible requester
//   o_idx   : chosen requester index (0 when o_valid = 0)
// ----------------------------------------------------------------------------
module lpc_rr_pick
    import lpc_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    // Each index gets a forward distance from the pointer; the smallest
    // distance among eligible requesters wins.
    always_comb begin
        int best_d;
        int d;
        best_d  = NUM_REQ;
        d       = 0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + NUM_REQ - int'(i_ptr));
            if (i_mask[i] && (d < best_d)) begin
                best_d  = d;
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lpc_reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// lpc_reg_write_arbiter
// Shares the register-bank write port between the LPC host decode path and
// NUM_REQ internal updaters. Host writes always win; internal writers are
// served round-robin over a req/gnt handshake and can be frozen by the host
// through bit0 of LOCK_ADDR.
//   i_LpcClock/i_PciReset : clock, async active-high reset
//   i_LpcWr/Addr/Data     : host write strobe and payload
//   i_Req/ReqAddr/ReqData : per-requester level request, 8-bit slices
//   o_Gnt/o_Drop          : one-cycle completion pulse; Drop = cancelled by host
//   o_RegWr/Addr/Data/Src : registered register-bank write (Src 7 = host)
//   o_Locked              : internal writes currently blocked
//   o_DeferCnt            : saturating count of host-deferred request cycles
// ----------------------------------------------------------------------------
module lpc_reg_write_arbiter
    import lpc_pkg::*;
#(
    parameter int         NUM_REQ   = 3,
    parameter logic [7:0] LOCK_ADDR = LOCK_ADDR_DEF
) (
    input  logic                 i_LpcClock,
    input  logic                 i_PciReset,
    input  logic                 i_LpcWr,
    input  logic [7:0]           i_LpcAddr,
    input  logic [7:0]           i_LpcData,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_ReqAddr,
    input  logic [8*NUM_REQ-1:0] i_ReqData,
    output logic [NUM_REQ-1:0]   o_Gnt,
    output logic [NUM_REQ-1:0]   o_Drop,
    output logic                 o_RegWr,
    output logic [7:0]           o_RegAddr,
    output logic [7:0]           o_RegData,
    output logic [2:0]           o_RegSrc,
    output logic                 o_Locked,
    output logic [7:0]           o_DeferCnt
);

    lock_state_t          r_lock;
    logic [IDX_W-1:0]     r_ptr;
    logic                 r_regwr;
    reg_wr_t              r_wr;
    logic [2:0]           r_src;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_drop;
    logic [7:0]           r_defer;

    reg_wr_t [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0]    w_elig;
    logic [NUM_REQ-1:0]    w_match;
    logic                  w_defer;
    logic                  w_pick_vld;
    logic [IDX_W-1:0]      w_pick_idx;
    logic [NUM_REQ-1:0]    w_pick_oh;
    reg_wr_t               w_sel;
    logic [IDX_W-1:0]      w_ptr_nxt;

    // A requester in its Gnt cycle is not eligible: it is still lowering or
    // replacing its request, so this blocks a double issue.
    assign w_elig  = i_Req & ~r_gnt;
    assign w_defer = i_LpcWr && |(w_elig & ~w_match);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign w_req[g]   = '{addr: i_ReqAddr[8*g +: 8], data: i_ReqData[8*g +: 8]};
        assign w_match[g] = w_elig[g] && (i_ReqAddr[8*g +: 8] == i_LpcAddr);
    end

    lpc_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_mask  (w_elig),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_sel     = '0;
        w_pick_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_sel        = w_req[i];
                w_pick_oh[i] = w_pick_vld;
            end
        end
    end

    assign w_ptr_nxt = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + IDX_W'(1);

    // Arbitration, output registers and the lock FSM share one block so the
    // lock state seen by arbitration is always the pre-edge value.
    always_ff @(posedge i_LpcClock or posedge i_PciReset) begin
        if (i_PciReset) begin
            r_lock  <= UNLOCKED;
            r_ptr   <= '0;
            r_regwr <= 1'b0;
            r_wr    <= '0;
            r_src   <= '0;
            r_gnt   <= '0;
            r_drop  <= '0;
            r_defer <= '0;
        end else begin
            r_regwr <= 1'b0;
            r_gnt   <= '0;
            r_drop  <= '0;
            if (i_LpcWr) begin
                // Host write: always issued; colliding requests are completed
                // as dropped since the host value supersedes them.
                r_regwr <= 1'b1;
                r_wr    <= '{addr: i_LpcAddr, data: i_LpcData};
                r_src   <= HOST_SRC;
                r_gnt   <= w_match;
                r_drop  <= w_match;
                if (w_defer && (r_defer != 8'hFF))
                    r_defer <= r_defer + 8'd1;
                if (i_LpcAddr == LOCK_ADDR)
                    r_lock <= i_LpcData[0] ? LOCKED : UNLOCKED;
            end else if ((r_lock == UNLOCKED) && w_pick_vld) begin
                r_regwr <= 1'b1;
                r_wr    <= w_sel;
                r_src   <= 3'(w_pick_idx);
                r_gnt   <= w_pick_oh;
                r_ptr   <= w_ptr_nxt;
            end
        end
    end

    assign o_Gnt      = r_gnt;
    assign o_Drop     = r_drop;
    assign o_RegWr    = r_regwr;
    assign o_RegAddr  = r_wr.addr;
    assign o_RegData  = r_wr.data;
    assign o_RegSrc   = r_src;
    assign o_Locked   = (r_lock == LOCKED);
    assign o_DeferCnt = r_defer;

endmodule

// File: doc/lpc_reg_write_arbiter.md
Name: lpc_reg_write_arbiter

Overview:
Shares the LPC register bank write port between the LPC host decode path and NUM_REQ internal hardware updaters (e.g. watchdog, fan monitor, power sequencer).
- Sits between the LPC decoder write outputs and the register bank write inputs.
- LPC host writes always win and are never stalled or dropped.
- Internal writers use a req/gnt handshake with round-robin arbitration, plus a host-controlled lock that freezes internal writes.

Parameters:
NUM_REQ, 3, number of internal write requesters (1..4)
LOCK_ADDR, 8'h1F, register address whose bit0 host-locks internal writes

Ports:
LpcClock  in  1  33 MHz LPC clock; all logic on rising edge
PciReset  in  1  reset, asynchronous, active-high
LpcWr  in  1  host write strobe, single-cycle pulse
LpcAddr  in  8  host write address, valid with LpcWr
LpcData  in  8  host write data, valid with LpcWr
Req  in  NUM_REQ  internal write request per requester, level
ReqAddr  in  8*NUM_REQ  per-requester address, slice i = [8i+7:8i]
ReqData  in  8*NUM_REQ  per-requester data, same slicing
Gnt  out  NUM_REQ  one-cycle completion pulse per requester
Drop  out  NUM_REQ  with Gnt: request cancelled by host write, not written
RegWr  out  1  register bank write strobe
RegAddr  out  8  register bank write address
RegData  out  8  register bank write data
RegSrc  out  3  source of current RegWr: 0..NUM_REQ-1 internal, 7 = host
Locked  out  1  internal writes currently blocked
DeferCnt  out  8  saturating count of internal-request cycles deferred by host writes

Behaviour:
- Reset values: all outputs 0, RegSrc = 0, RR pointer = 0, lock FSM = UNLOCKED. Assertion at any time aborts the in-flight issue; no Gnt is produced for it.
- Registered pipeline: arbitration on inputs in cycle k; RegWr/RegAddr/RegData/RegSrc/Gnt/Drop valid in k+1 for exactly one cycle.
- Eligible set in cycle k: Req[i] = 1 and Gnt[i] = 0 in cycle k. The requester drops or changes Req/ReqAddr/ReqData in the Gnt cycle, so no double issue.
- Host path: LpcWr in k gives RegWr = 1, RegAddr = LpcAddr, RegData = LpcData, RegSrc = 7 in k+1, regardless of lock or pending requests.
- Host collision: LpcWr in k and eligible i with ReqAddr_i == LpcAddr gives Gnt[i] = Drop[i] = 1 in k+1. All matching requesters are dropped in the same cycle. The RR pointer is unchanged.
- Host deferral: LpcWr in k with at least one eligible, non-matching requester leaves those requesters pending. DeferCnt increments by 1 per such cycle, saturating at 8'hFF.
- Internal path: no LpcWr in k, FSM UNLOCKED, and eligible set non-empty. Pick the first eligible index at or after the RR pointer (wrapping NUM_REQ-1 to 0).
  - In k+1: RegWr = 1, address/data from that slice, RegSrc = index, Gnt[index] = 1, Drop = 0.
  - RR pointer = index+1, wrapping to 0 after NUM_REQ-1.
- Lock FSM, states UNLOCKED/LOCKED:
  - Host write to LOCK_ADDR with LpcData[0] = 1 moves to LOCKED.
  - Host write to LOCK_ADDR with LpcData[0] = 0 moves to UNLOCKED.
  - Transition takes effect for arbitration from k+1. Locked mirrors the state.
- LOCKED behaviour:
  - Internal requests are held; no Gnt except host-collision drops. DeferCnt does not count lock stalls.
  - The host LOCK_ADDR write itself still propagates to RegWr.
- Idle (no LpcWr, empty eligible set, or LOCKED with no collision): RegWr = 0. RegAddr/RegData/RegSrc hold their previous values.

Decomposition:
- Shared package lpc_pkg:
  - HOST_SRC = 3'd7, LOCK_ADDR default.
  - lock_state_t enum {UNLOCKED, LOCKED}.
  - typedef reg_wr_t {addr[7:0], data[7:0]}.
- One sub-module, lpc_rr_pick: combinational round-robin picker over the eligible mask and pointer; returns valid and index.

Test Plan:
- Reset then single Req[1], addr 8'h05, data 8'hA5 -> next cycle RegWr = 1, RegAddr = 05, RegData = A5, RegSrc = 1, Gnt[1] = 1 for one cycle.
- Req = 3'b111 held, re-raised after each Gnt -> grant order 0,1,2,0,… with one RegWr per cycle and no gaps.
- LpcWr addr 8'h10 in the same cycle as Req[0] addr 8'h20 -> k+1: host write, RegSrc = 7; k+2: Req[0] written; DeferCnt = 1.
- LpcWr addr 8'h20 data 8'h33 while Req[0] and Req[2] both pending at 8'h20 -> k+1: RegData = 33, Gnt[0] = Gnt[2] = 1 with Drop set, no internal write.
- Host writes LOCK_ADDR with 8'h01, then Req[1] held 20 cycles -> Locked = 1, no Gnt. Host writes 8'h00 -> Locked = 0, Req[1] granted 2 cycles after the unlock write.
- Assert PciReset mid-burst with Req = 3'b011 -> all outputs 0 immediately. After deassertion, grant order restarts at requester 0.
